// File: rtl/io_bus_master.sv
// io_bus_master: CPU-side initiator for the memory-mapped IO bus.
// A single-word CPU request becomes a timed io_cs/io_rd/io_wr cycle
// (IDLE -> SETUP -> STROBE -> HOLD). Read data is captured into rdata.
// The block also owns the initiator side of the interrupt handshake:
// intr is synchronised, presented as irq_pending, and acknowledged on int_ack.
// Optional feature macro: IO_ALIGN_CHECK_EN. When it is defined, requests
// with a misaligned address or an address past the last full word are
// rejected with a one-cycle err pulse. When it is undefined, err stays 0.
module io_bus_master #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int ACK_CYC    = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              io_cs,
    output logic              io_rd,
    output logic              io_wr,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] IO_in,
    input  logic [DATA_W-1:0] IO_out,
    input  logic              intr,
    output logic              int_ack,
    output logic              irq_pending,
    input  logic              irq_take
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} bus_state_t;
    typedef enum logic [1:0] {I_IDLE, I_PEND, I_ACK, I_WAIT} irq_state_t;

    bus_state_t state_reg;
    irq_state_t irq_state_reg;
    logic [3:0] cnt_reg;
    logic [3:0] ack_cnt_reg;
    logic       wr_reg;
    logic       intr_meta_reg;
    logic       intr_s;
    logic       reject;

`ifdef IO_ALIGN_CHECK_EN
    // Highest address at which a whole word still fits inside the IO window.
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}} - ADDR_W'(3);
    assign reject = (req_addr[1:0] != 2'b00) || (req_addr > ADDR_MAX);
`else
    assign reject = 1'b0;
`endif

    // Bus cycle sequencer; all bus-side outputs are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            io_cs     <= 1'b0;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            Address   <= '0;
            IO_in     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            state_reg <= SETUP;
                            cnt_reg   <= 4'(SETUP_CYC - 1);
                            wr_reg    <= req_wr;
                            busy      <= 1'b1;
                            io_cs     <= 1'b1;
                            Address   <= req_addr;
                            IO_in     <= req_wdata;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= STROBE;
                        cnt_reg   <= 4'(STROBE_CYC - 1);
                        io_rd     <= !wr_reg;
                        io_wr     <= wr_reg;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_reg == 4'd0) begin
                        // Capture at the edge closing the last strobe cycle so
                        // the responder has had the full strobe to drive data.
                        if (!wr_reg) begin
                            rdata <= IO_out;
                        end
                        state_reg <= HOLD;
                        io_rd     <= 1'b0;
                        io_wr     <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    io_cs     <= 1'b0;
                    Address   <= '0;
                    IO_in     <= '0;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            intr_meta_reg <= 1'b0;
            intr_s        <= 1'b0;
        end else begin
            intr_meta_reg <= intr;
            intr_s        <= intr_meta_reg;
        end
    end

    // Interrupt handshake; runs independently of the bus sequencer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_state_reg <= I_IDLE;
            ack_cnt_reg   <= '0;
            int_ack       <= 1'b0;
            irq_pending   <= 1'b0;
        end else begin
            case (irq_state_reg)
                I_IDLE: begin
                    if (intr_s) begin
                        irq_state_reg <= I_PEND;
                        irq_pending   <= 1'b1;
                    end
                end
                I_PEND: begin
                    // A take wins over a simultaneous drop of the request.
                    if (irq_take) begin
                        irq_state_reg <= I_ACK;
                        irq_pending   <= 1'b0;
                        int_ack       <= 1'b1;
                        ack_cnt_reg   <= 4'(ACK_CYC - 1);
                    end else if (!intr_s) begin
                        irq_state_reg <= I_IDLE;
                        irq_pending   <= 1'b0;
                    end
                end
                I_ACK: begin
                    if (ack_cnt_reg == 4'd0) begin
                        irq_state_reg <= I_WAIT;
                        int_ack       <= 1'b0;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    // A request still held high after the ack must not re-pend.
                    if (!intr_s) begin
                        irq_state_reg <= I_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
